sort4_sequencer: RTL and testbench

Sequential controller for the 4-element unsigned sorter datapath. It time-multiplexes a single compare-and-swap unit through the fixed 5-comparator sorting network for 4 inputs: (0,1), (2,3), (0,2), (1,3), (1,2). Each stage produces at most one swap. Input and output are valid/ready handshakes carrying packed vectors, so the block can sit between a stimulus/producer stage and a consumer.

---
 rtl/sort4_sequencer.sv | 125 ++++++++++++
 tb/tb_sort4_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sort4_sequencer.sv
// Sequential 4-element unsigned sorter: one compare-and-swap unit stepped through
// the 5-comparator network (0,1),(2,3),(0,2),(1,3),(1,2) with valid/ready on both sides.
module sort4_sequencer #(
  parameter int data_width = 3,
  parameter int num_elems  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [num_elems*data_width-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [num_elems*data_width-1:0] out_data,
  output logic                            busy,
  output logic [2:0]                      swap_count
);

  // The comparator schedule below is wired for exactly four elements.
  if (num_elems != 4) begin : g_bad_num_elems
    $error("sort4_sequencer: num_elems must be 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                                  state_r;
  logic [num_elems-1:0][data_width-1:0]    work_r;
  logic [num_elems-1:0][data_width-1:0]    swapped_s;
  logic [2:0]                              step_r;
  logic [2:0]                              swap_count_r;
  logic                                    in_ready_r;
  logic                                    out_valid_r;
  logic                                    busy_r;
  logic [1:0]                              idx_a_s;
  logic [1:0]                              idx_b_s;
  logic                                    swap_s;

  // Comparator pair for the current step and the swapped working vector.
  always_comb begin
    idx_a_s   = 2'd0;
    idx_b_s   = 2'd1;
    case (step_r)
      3'd0:    begin idx_a_s = 2'd0; idx_b_s = 2'd1; end
      3'd1:    begin idx_a_s = 2'd2; idx_b_s = 2'd3; end
      3'd2:    begin idx_a_s = 2'd0; idx_b_s = 2'd2; end
      3'd3:    begin idx_a_s = 2'd1; idx_b_s = 2'd3; end
      3'd4:    begin idx_a_s = 2'd1; idx_b_s = 2'd2; end
      default: begin idx_a_s = 2'd0; idx_b_s = 2'd1; end
    endcase
    swap_s    = (work_r[idx_a_s] > work_r[idx_b_s]);
    swapped_s = work_r;
    if (swap_s) begin
      swapped_s[idx_a_s] = work_r[idx_b_s];
      swapped_s[idx_b_s] = work_r[idx_a_s];
    end else begin
      swapped_s = work_r;
    end
  end

  // Control FSM with registered handshake/status outputs and the working register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      work_r       <= '0;
      step_r       <= 3'd0;
      swap_count_r <= 3'd0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            work_r       <= in_data;
            swap_count_r <= 3'd0;
            step_r       <= 3'd0;
            in_ready_r   <= 1'b0;
            busy_r       <= 1'b1;
            state_r      <= SORT;
          end
        end
        SORT: begin
          work_r <= swapped_s;
          if (swap_s) begin
            swap_count_r <= swap_count_r + 3'd1;
          end
          if (step_r == 3'd4) begin
            step_r      <= 3'd0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            step_r <= step_r + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          // Unreachable encoding: return to a clean idle state.
          step_r      <= 3'd0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign swap_count = swap_count_r;
  assign out_data   = work_r;

endmodule

// File: tb/tb_sort4_sequencer.sv
// Self-checking bench for sort4_sequencer: a cycle-level reference model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_sort4_sequencer;

  localparam int W  = 3;
  localparam int N  = 4;
  localparam int VW = W * N;

  logic          tb_clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [VW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic          busy;
  logic [VW-1:0] out_data;
  logic [2:0]    swap_count;

  always #5 tb_clk = ~tb_clk;

  sort4_sequencer #(.data_width(W), .num_elems(N)) dut (
    .clk        (tb_clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .swap_count (swap_count)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  bit cap_en   = 1'b0;
  logic [VW-1:0] got_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Apply the 5-comparator network to a packed vector; returns {count, sorted}.
  function automatic logic [15:0] net_sort(input logic [VW-1:0] din);
    int e[4];
    int sa[5] = '{0, 2, 0, 1, 1};
    int sb[5] = '{1, 3, 2, 3, 2};
    int cnt = 0;
    int t;
    logic [VW-1:0] dout;
    for (int i = 0; i < 4; i++) e[i] = int'(din[i*W +: W]);
    for (int s = 0; s < 5; s++) begin
      if (e[sa[s]] > e[sb[s]]) begin
        t = e[sa[s]]; e[sa[s]] = e[sb[s]]; e[sb[s]] = t; cnt++;
      end
    end
    for (int i = 0; i < 4; i++) dout[i*W +: W] = W'(e[i]);
    return {4'(cnt), dout};
  endfunction

  // Reference model: accept when ready, result 5 cycles later, held until taken.
  bit            m_in_ready  = 1'b1;
  bit            m_out_valid = 1'b0;
  bit            m_busy      = 1'b0;
  logic [VW-1:0] m_data      = '0;
  logic [3:0]    m_cnt       = 4'd0;
  logic [15:0]   m_res       = 16'd0;
  int            m_timer     = 0;

  always @(posedge tb_clk) begin
    if (rst) begin
      m_in_ready  <= 1'b1;
      m_out_valid <= 1'b0;
      m_busy      <= 1'b0;
      m_data      <= '0;
      m_cnt       <= 4'd0;
      m_timer     <= 0;
    end else if (m_in_ready && in_valid) begin
      m_res      <= net_sort(in_data);
      m_in_ready <= 1'b0;
      m_busy     <= 1'b1;
      m_timer    <= 5;
    end else if (m_timer > 0) begin
      m_timer <= m_timer - 1;
      if (m_timer == 1) begin
        m_out_valid <= 1'b1;
        m_data      <= m_res[VW-1:0];
        m_cnt       <= m_res[15:12];
      end
    end else if (m_out_valid && out_ready) begin
      m_out_valid <= 1'b0;
      m_busy      <= 1'b0;
      m_in_ready  <= 1'b1;
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge tb_clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_in_ready));
      chk("out_valid", 32'(out_valid), 32'(m_out_valid));
      chk("busy", 32'(busy), 32'(m_busy));
      if (m_out_valid) begin
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("swap_count", 32'(swap_count), 32'(m_cnt));
      end
      if (cap_en && out_valid && out_ready) got_q.push_back(out_data);
    end
  end

  task automatic run_vec(input logic [VW-1:0] din, input logic [VW-1:0] exp_d,
                         input int exp_c, input string nm);
    int cyc;
    in_data  = din;
    in_valid = 1'b1;
    @(negedge tb_clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge tb_clk);
      cyc++;
    end
    chk({nm, " latency"}, 32'(cyc), 32'd5);
    chk({nm, " data"}, 32'(out_data), 32'(exp_d));
    chk({nm, " swaps"}, 32'(swap_count), 32'(exp_c));
    @(negedge tb_clk);
    chk({nm, " in_ready after"}, 32'(in_ready), 32'd1);
  endtask

  logic [VW-1:0] v_mixed, v_mixed_s, v_rev, v_rev_s, v_bp, v_bp_s;
  logic [VW-1:0] b2b_in[3];
  logic [VW-1:0] b2b_exp[3];
  longint        t_acc[3];

  initial begin
    int cyc;
    v_mixed   = {3'd1, 3'd7, 3'd3, 3'd5};
    v_mixed_s = {3'd7, 3'd5, 3'd3, 3'd1};
    v_rev     = {3'd4, 3'd5, 3'd6, 3'd7};
    v_rev_s   = {3'd7, 3'd6, 3'd5, 3'd4};
    v_bp      = {3'd0, 3'd4, 3'd1, 3'd6};
    v_bp_s    = {3'd6, 3'd4, 3'd1, 3'd0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;

    chk("model mixed", 32'(net_sort(v_mixed)), 32'({4'd4, v_mixed_s}));
    chk("model reverse", 32'(net_sort(v_rev)), 32'({4'd4, v_rev_s}));
    chk("model max swaps", 32'(net_sort(v_bp)), 32'({4'd5, v_bp_s}));

    @(negedge tb_clk);
    @(negedge tb_clk);
    chk_en = 1'b1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset swap_count", 32'(swap_count), 32'd0);
    rst = 1'b0;

    run_vec(v_mixed, v_mixed_s, 4, "mixed");
    run_vec(v_rev, v_rev_s, 4, "reverse");
    run_vec({3'd4, 3'd3, 3'd2, 3'd1}, {3'd4, 3'd3, 3'd2, 3'd1}, 0, "sorted");
    run_vec({3'd2, 3'd2, 3'd2, 3'd2}, {3'd2, 3'd2, 3'd2, 3'd2}, 0, "equal");

    // Backpressure: hold the result 10 cycles while a new vector is offered.
    out_ready = 1'b0;
    in_data   = v_bp;
    in_valid  = 1'b1;
    @(negedge tb_clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge tb_clk);
      cyc++;
    end
    chk("bp latency", 32'(cyc), 32'd5);
    in_data  = v_mixed;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge tb_clk);
      chk("bp hold data", 32'(out_data), 32'(v_bp_s));
      chk("bp hold swaps", 32'(swap_count), 32'd5);
      chk("bp hold valid", 32'(out_valid), 32'd1);
      chk("bp in_ready low", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge tb_clk);
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    chk("bp not accepted", 32'(busy), 32'd0);

    // Reset in the third SORT cycle discards the vector.
    in_data  = v_rev;
    in_valid = 1'b1;
    @(negedge tb_clk);
    in_valid = 1'b0;
    @(negedge tb_clk);
    @(negedge tb_clk);
    rst = 1'b1;
    @(negedge tb_clk);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst swap_count", 32'(swap_count), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    run_vec({3'd1, 3'd7, 3'd0, 3'd0}, {3'd7, 3'd1, 3'd0, 3'd0}, 1, "post reset");

    // Back-to-back with in_valid held high.
    b2b_in[0]  = v_mixed; b2b_exp[0] = v_mixed_s;
    b2b_in[1]  = v_bp;    b2b_exp[1] = v_bp_s;
    b2b_in[2]  = v_rev;   b2b_exp[2] = v_rev_s;
    got_q.delete();
    cap_en   = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = b2b_in[k];
      cyc = 0;
      while (!in_ready && cyc < 20) begin
        @(negedge tb_clk);
        cyc++;
      end
      t_acc[k] = longint'($time);
      @(negedge tb_clk);
    end
    in_valid = 1'b0;
    cyc = 0;
    while (got_q.size() < 3 && cyc < 30) begin
      @(negedge tb_clk);
      cyc++;
    end
    @(negedge tb_clk);
    cap_en = 1'b0;
    chk("b2b interval 1", 32'(t_acc[1] - t_acc[0]), 32'd70);
    chk("b2b interval 2", 32'(t_acc[2] - t_acc[1]), 32'd70);
    chk("b2b count", 32'(got_q.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < got_q.size()) chk("b2b result", 32'(got_q[k]), 32'(b2b_exp[k]));
      else chk("b2b result missing", 32'd0, 32'(b2b_exp[k]));
    end

    repeat (3) @(negedge tb_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
